// File: rtl/game_over_banner_mover_pkg.sv
// game_over_banner_mover_pkg: shared geometry and FSM state constants for the banner mover.
package game_over_banner_mover_pkg;
    localparam int CORDW       = 10;
    localparam int SCREEN_W    = 640;
    localparam int GAME_OVER_W = 256;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SLIDE = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;
    localparam logic [1:0] ST_BLINK = 2'd3;
endpackage

// File: rtl/game_over_banner_mover_frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse per frame, the cycle after (line==TICK_LINE && pixel==0) is first seen.
module frame_tick_gen
    import game_over_banner_mover_pkg::*;
#(
    parameter int TICK_LINE = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CORDW-1:0] i_pixel,
    input  logic [CORDW-1:0] i_line,
    output logic             o_tick
);
    logic r_hit, r_hit_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit   <= 1'b0;
            r_hit_q <= 1'b0;
        end else begin
            r_hit   <= (i_line == CORDW'(TICK_LINE)) && (i_pixel == '0);
            r_hit_q <= r_hit;
        end
    end
    // Edge detect so a multi-cycle pixel==0 window still yields a single tick.
    assign o_tick = r_hit & ~r_hit_q;
endmodule

// File: rtl/game_over_banner_mover.sv
// game_over_banner_mover: slides the GAME OVER banner in from the right, parks it centred,
// holds it, then blinks it until restart; x only moves on the vertical-blanking frame tick.
module game_over_banner_mover
    import game_over_banner_mover_pkg::*;
#(
    parameter int START_X      = 640,
    parameter int TARGET_X     = (SCREEN_W - GAME_OVER_W) / 2,
    parameter int STEP         = 4,
    parameter int TICK_LINE    = 480,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CORDW-1:0] i_pixel,
    input  logic [CORDW-1:0] i_line,
    input  logic             i_game_over,
    input  logic             i_restart,
    output logic [9:0]       o_game_over_x,
    output logic             o_banner_en,
    output logic             o_settled
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic          w_tick, w_go_rise, w_arrive;
    logic [10:0]   w_nx;
    logic          r_go_q, r_en, r_settled;
    logic [1:0]    r_state;
    logic [9:0]    r_x;
    logic [HW-1:0] r_hold;
    logic [BW-1:0] r_blink;
    frame_tick_gen #(.TICK_LINE(TICK_LINE)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_pixel (i_pixel),
        .i_line  (i_line),
        .o_tick  (w_tick)
    );
    assign w_go_rise = i_game_over & ~r_go_q;
    // 11-bit signed step so an overshoot below TARGET_X clamps instead of wrapping.
    assign w_nx      = {1'b0, r_x} - 11'(STEP);
    assign w_arrive  = $signed(w_nx) <= $signed(11'(TARGET_X));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_go_q    <= 1'b0;
            r_state   <= ST_IDLE;
            r_x       <= 10'(START_X);
            r_en      <= 1'b0;
            r_settled <= 1'b0;
            r_hold    <= '0;
            r_blink   <= '0;
        end else begin
            r_go_q    <= i_game_over;
            r_settled <= 1'b0;
            if (i_restart) begin
                r_state <= ST_IDLE;
                r_x     <= 10'(START_X);
                r_en    <= 1'b0;
                r_hold  <= '0;
                r_blink <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_go_rise) r_state <= ST_SLIDE;
                    ST_SLIDE: if (w_tick) begin
                        r_en <= 1'b1;
                        if (w_arrive) begin
                            r_x       <= 10'(TARGET_X);
                            r_settled <= 1'b1;
                            r_state   <= ST_SHOW;
                        end else begin
                            r_x <= w_nx[9:0];
                        end
                    end
                    ST_SHOW: if (w_tick) begin
                        if (r_hold == HW'(HOLD_FRAMES - 1)) begin
                            r_state <= ST_BLINK;
                            r_hold  <= '0;
                            r_blink <= '0;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    default: if (w_tick) begin
                        if (r_blink == BW'(BLINK_FRAMES - 1)) begin
                            r_blink <= '0;
                            r_en    <= ~r_en;
                        end else begin
                            r_blink <= r_blink + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
    assign o_game_over_x = r_x;
    assign o_banner_en   = r_en;
    assign o_settled     = r_settled;
endmodule
